// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD converter (double-dabble, one bit per cycle) feeding a
// five-digit multiplexed display with leading-zero blanking.
module bcd_display_ctrl #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        enable,
  output logic        busy,
  output logic        done,
  output logic [4:0]  digit_sel,
  output logic [3:0]  digit_val
);

  // state  | meaning
  // IDLE   | waiting for load; display shows last committed result
  // CONV   | 16 double-dabble steps, one bit per cycle
  // COMMIT | accumulator copied (blanked) into display on exit edge
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] disp_q, disp_d;
  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [4:0]  sel_q, sel_d;
  logic [3:0]  val_q, val_d;

  logic [19:0] adj;
  logic [19:0] blanked;
  logic        lead;

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // D1 is never blanked so a zero result still shows a single 0.
  always_comb begin
    blanked = acc_q;
    lead    = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (acc_q[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead) blanked[4*i +: 4] = 4'hF;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d    = value;
          acc_d   = 20'd0;
          cnt_d   = 4'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        {acc_d, sr_d} = {adj[18:0], sr_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = blanked;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan path runs free of the FSM and of enable; only the outputs are gated.
  always_comb begin
    presc_d = presc_q + 16'd1;
    idx_d   = idx_q;
    if (presc_q == 16'(SCAN_DIV - 1)) begin
      presc_d = 16'd0;
      idx_d   = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end
    sel_d = 5'b00000;
    val_d = 4'hF;
    if (enable) begin
      sel_d = 5'b00001 << idx_q;
      val_d = disp_q[{idx_q, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= 16'd0;
      acc_q   <= 20'd0;
      cnt_q   <= 4'd0;
      disp_q  <= 20'hFFFFF;
      presc_q <= 16'd0;
      idx_q   <= 3'd0;
      sel_q   <= 5'b00000;
      val_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == COMMIT);
  assign digit_sel = sel_q;
  assign digit_val = val_q;

endmodule

// File: doc/bcd_display_ctrl.md
BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit stays selected (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port load  input  1  request to convert value; sampled only in IDLE.
REQ-005 SHALL have port value  input  16  unsigned binary number to display.
REQ-006 SHALL have port enable  input  1  0 = display blanked; 1 = display shown.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the converted result is committed.
REQ-009 SHALL have port digit_sel  output  5  one-hot digit strobe, bit 0 = D1 (units) .. bit 4 = D5 (ten-thousands).
REQ-010 SHALL have port digit_val  output  4  BCD code for the selected digit; 4'b1111 = blank.

Function
REQ-011 SHALL implement FSM states IDLE, CONV, COMMIT; busy = (state != IDLE); done = (state == COMMIT).
REQ-012 SHALL, in IDLE with load=1 at an edge, capture value into a 16-bit shift register, clear a 20-bit BCD accumulator and a 4-bit iteration counter, and enter CONV.
REQ-013 SHALL, in each CONV cycle, add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by one bit (double-dabble).
REQ-014 SHALL stay in CONV for exactly 16 cycles, then enter COMMIT for exactly one cycle, then return to IDLE.
REQ-015 SHALL have done high exactly 17 cycles after the capturing edge, i.e. during the cycle after the 16th CONV cycle.
REQ-016 SHALL copy the five accumulator nibbles into the display registers D1..D5 at the edge ending COMMIT.
REQ-017 SHALL apply leading-zero blanking on that copy: every digit above the most significant nonzero digit is stored as 4'b1111.
REQ-018 SHALL store value 0 as D1 = 0 and D2..D5 = 4'b1111.
REQ-019 SHALL ignore load whenever state is CONV or COMMIT; no queuing, and the in-flight conversion is unaffected.
REQ-020 SHALL let load asserted in the cycle after COMMIT (state IDLE) start a new conversion normally.
REQ-021 SHALL hold the display registers unchanged during a conversion; the old result stays visible until commit.
REQ-022 SHALL use a scan prescaler counting 0..SCAN_DIV-1 that advances the digit index 0->1->2->3->4->0 at each wrap.
REQ-023 SHALL run the prescaler and digit index independently of the FSM and of enable.
REQ-024 SHALL register digit_sel as the one-hot of the digit index when enable=1, and as 5'b00000 when enable=0.
REQ-025 SHALL drive digit_val as the display register selected by the digit index when enable=1, and as 4'b1111 when enable=0.
REQ-026 SHALL change digit_sel and digit_val on the same edge; they are never mismatched.

Reset
REQ-027 SHALL, on rst=1, immediately and asynchronously set: state IDLE; busy 0; done 0; prescaler 0; digit index 0; D1..D5 = 4'b1111.
REQ-028 SHALL, on rst=1, set digit_sel 5'b00000; digit_sel becomes 5'b00001 at the first edge after release if enable=1.
REQ-029 SHALL abort any in-flight conversion on rst without committing partial results; no done pulse is produced.

Verification
REQ-030 SHALL cover: reset, enable=1, no load -> busy=0, done never pulses, digit_val=4'b1111 on all five strobes, digit_sel rotates every SCAN_DIV cycles.
REQ-031 SHALL cover: load value=65535 -> busy high 17 cycles, done on cycle 17; then D5..D1 = 6,5,5,3,5.
REQ-032 SHALL cover: load value=307 -> D1=7, D2=0, D3=3, D4=D5=4'b1111; load value=0 -> D1=0, others 4'b1111.
REQ-033 SHALL cover: load 1000, then load 1234 at cycle 5 of CONV -> exactly one done; D4..D1 = 1,0,0,0.
REQ-034 SHALL cover: rst asserted at cycle 8 of a conversion -> busy=0 at once, all digits 4'b1111, no done pulse.
REQ-035 SHALL cover: enable=0 during scan -> digit_sel=0, digit_val=4'b1111, and the digit index still advances (on re-enable, display resumes at the advanced index).
